alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Multi-cycle issue/writeback controller sitting directly upstream of `alu_with_flags`. It accepts register-form or immediate-form instructions over a valid/ready handshake and reads operands from a small internal register file. It drives the ALU's `a`/`b`/`op` inputs, then writes the result back and latches the carry/zero/overflow flags into a status register. It is the first sequential stage wrapped around the combinational ALU.

## Interface
Parameters:
- `DATA_W`, 4: operand/result width; must match ALU width.
- `NREG`, 4: register-file depth; address width is `$clog2(NREG)` (AW).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  instruction offered.
- `instr_ready`  out  1  controller can accept; equals (state == IDLE).
- `instr_op`  in  3  ALU opcode, passed unchanged.
- `instr_rd`, `instr_rs1`, `instr_rs2`  in  AW each  destination and source registers.
- `instr_imm_en`  in  1  if 1, operand b = `instr_imm` instead of reg[rs2].
- `instr_imm`  in  DATA_W  immediate.
- `alu_a`, `alu_b`  out  DATA_W  to ALU.
- `alu_op`  out  3  to ALU.
- `alu_result`  in  DATA_W  from ALU.
- `alu_carry`, `alu_zero`, `alu_overflow`  in  1 each  from ALU.
- `wb_valid`  out  1  one-cycle writeback strobe.
- `wb_rd`  out  AW  writeback register.
- `wb_data`  out  DATA_W  writeback value.
- `flag_c`, `flag_z`, `flag_v`  out  1 each  status register.
- `flag_clr`  in  1  clear sticky overflow (see Configuration).
- `dbg_addr`  in  AW  debug read address.
- `dbg_data`  out  DATA_W  combinational reg[dbg_addr].

## Operation
- FSM states: IDLE, EXEC, WB.
  - IDLE → EXEC on `instr_valid && instr_ready`; all instr fields captured into an instruction register.
  - EXEC → WB unconditionally; `alu_result` and the three flags are captured into `wb_data` and the pending-flag registers.
  - WB → IDLE unconditionally; reg[wb_rd] ← `wb_data`; `flag_c`/`flag_z`/`flag_v` updated.
- `alu_a` = reg[held rs1]. `alu_b` = held imm if held imm_en, else reg[held rs2]. `alu_op` = held op. All three are driven from held values in every state; only the EXEC sample matters.
- Unary and shift ops: b is still driven and the ALU ignores it.
- Loading a constant uses an immediate-form OR with r0 (r0 is an ordinary register and is 0 after reset). There is no hard-wired zero register.
- `instr_*` inputs are ignored whenever `instr_ready` = 0. The producer holds its fields until accepted.
- Reset (async assert): state IDLE, instr register 0, all registers 0, `wb_valid` 0, `wb_rd` 0, `wb_data` 0, all flags 0, `instr_ready` 1. Alu outputs read 0 as a consequence.
- Reset mid-EXEC or mid-WB aborts the operation. No writeback occurs and no flag changes.

## Timing
- Accept at edge E0 → EXEC cycle → capture at E1 → `wb_valid`=1 for exactly the cycle E1–E2 → regfile and flags visible after E2.
- Latency from accept to `wb_valid`: 1 cycle. Issue interval: 3 cycles minimum; next accept is earliest at E3.
- No RAW hazard: the writeback commits at E2, before the next EXEC reads.
- `dbg_data` reflects the write from the cycle after E2.

## Configuration
- `ALU_ISSUE_STICKY_V_EN` defined: `flag_v` is sticky. In WB, flag_v ← flag_v | captured V. `flag_clr`=1 clears it at the next edge. If clear and a WB set occur in the same cycle, set wins.
- Not defined: `flag_v` = V of the last completed op, and `flag_clr` is ignored.
- `flag_c`/`flag_z` are always last-op values.

## Structure
- Shared package `alu_pkg`:
  - opcode constants OP_ADD..OP_SHR (000..111);
  - FSM state encodings;
  - DATA_W default.
- The register file is a natural sub-module: `alu_regfile`, with 2 combinational read ports, a debug read port, 1 synchronous write port, and async clear.
- The ALU itself is instantiated by the parent, not inside this block.

## Test plan
- Reset: all flags 0, `instr_ready`=1, `wb_valid`=0, `dbg_data`=0 for every address.
- OR r1,r0,#7; OR r2,r0,#9; ADD r3,r1,r2 → ADD writeback has `wb_rd`=3, `wb_data`=0; flags C=1, Z=1, V=0; `dbg_addr`=3 reads 0.
- OR r1,r0,#8; ADD r2,r1,#8 → `wb_data`=0, C=1, Z=1, V=1.
- `instr_valid` held high with two queued instructions → `instr_ready` low for 2 cycles; second accept exactly 3 edges after the first; exactly one `wb_valid` pulse per instruction.
- `rst_n` pulsed low during EXEC of SUB r1,r0,#3 → no `wb_valid`; r1=0; flags 000; `instr_ready`=1 immediately.
- With the macro: V set by 8+8, then AND r3,r1,r1 → `flag_v` stays 1; `flag_clr` pulse → 0. Without the macro: `flag_v`=0 after the AND.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, controller FSM states and the C/Z/V flag bundle shared by the
// issue controller, its register file and the bench.
package alu_pkg;

  localparam int DATA_W_DEF = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  typedef struct packed {
    logic c;
    logic z;
    logic v;
  } flags_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: instruction valid/ready channel into alu_issue_ctrl.
// master = instruction producer, slave = controller.
interface alu_issue_ctrl_if #(
  parameter int DATA_W = alu_pkg::DATA_W_DEF,
  parameter int AW     = 2
);
  logic              instr_valid;
  logic              instr_ready;
  logic [2:0]        instr_op;
  logic [AW-1:0]     instr_rd;
  logic [AW-1:0]     instr_rs1;
  logic [AW-1:0]     instr_rs2;
  logic              instr_imm_en;
  logic [DATA_W-1:0] instr_imm;

  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm_en, instr_imm,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm_en, instr_imm,
    output instr_ready
  );
endinterface

// File: rtl/alu_regfile.sv
// alu_regfile: NREG x DATA_W register file, two combinational operand reads, one
// combinational debug read, one synchronous write port, asynchronous clear.
module alu_regfile #(
  parameter int  DATA_W = alu_pkg::DATA_W_DEF,
  parameter int  NREG   = 4,
  localparam int AW     = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     rs1_addr,
  output logic [DATA_W-1:0] rs1_data,
  input  logic [AW-1:0]     rs2_addr,
  output logic [DATA_W-1:0] rs2_data,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[wr_addr] = wr_data;
  end

  // NOTE: this is a handful of flops, not a RAM macro, so it is cleared by reset;
  // r0 reading 0 after reset is what the OR-with-r0 constant-load idiom relies on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end

  assign rs1_data = regs_q[rs1_addr];
  assign rs2_data = regs_q[rs2_addr];
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: IDLE -> EXEC -> WB issue/writeback controller wrapped around alu_with_flags.
// Define ALU_ISSUE_STICKY_V_EN to make flag_v sticky and clearable through flag_clr.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int  DATA_W = DATA_W_DEF,
  parameter int  NREG   = 4,
  localparam int AW     = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_ctrl_if.slave   iss,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  output logic              wb_valid,
  output logic [AW-1:0]     wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              flag_c,
  output logic              flag_z,
  output logic              flag_v,
  input  logic              flag_clr,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef struct packed {
    logic [2:0]        op;
    logic [AW-1:0]     rd;
    logic [AW-1:0]     rs1;
    logic [AW-1:0]     rs2;
    logic              imm_en;
    logic [DATA_W-1:0] imm;
  } instr_t;

  state_e            state_q, state_d;
  instr_t            instr_q, instr_d;
  logic              ready_q, ready_d;
  logic              wb_valid_q, wb_valid_d;
  logic [AW-1:0]     wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  flags_t            pend_q, pend_d;
  flags_t            flags_q, flags_d;
  logic              rf_we;
  logic [DATA_W-1:0] rs1_data, rs2_data;

  alu_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (instr_q.rs1),
    .rs1_data (rs1_data),
    .rs2_addr (instr_q.rs2),
    .rs2_data (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (rf_we),
    .wr_addr  (wb_rd_q),
    .wr_data  (wb_data_q)
  );

  // Operands come from the held instruction in every state; the ALU result is only sampled in EXEC.
  assign alu_a  = rs1_data;
  assign alu_b  = instr_q.imm_en ? instr_q.imm : rs2_data;
  assign alu_op = instr_q.op;

  always_comb begin
    // NOTE: every _d starts from a full default so no path through the case can infer a latch.
    state_d    = state_q;
    instr_d    = instr_q;
    ready_d    = ready_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    pend_d     = pend_q;
    flags_d    = flags_q;
    rf_we      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (iss.instr_valid && ready_q) begin
          instr_d = '{op:     iss.instr_op,
                      rd:     iss.instr_rd,
                      rs1:    iss.instr_rs1,
                      rs2:    iss.instr_rs2,
                      imm_en: iss.instr_imm_en,
                      imm:    iss.instr_imm};
          state_d = ST_EXEC;
          ready_d = 1'b0;
        end
      end
      ST_EXEC: begin
        wb_data_d  = alu_result;
        wb_rd_d    = instr_q.rd;
        pend_d     = '{c: alu_carry, z: alu_zero, v: alu_overflow};
        wb_valid_d = 1'b1;
        state_d    = ST_WB;
      end
      ST_WB: begin
        // Commit lands on the WB->IDLE edge, before any following EXEC can read it.
        rf_we   = 1'b1;
        flags_d = pend_q;
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase

`ifdef ALU_ISSUE_STICKY_V_EN
    // A clear and a writeback set on the same edge resolve to set.
    flags_d.v = (flags_q.v && !flag_clr) || ((state_q == ST_WB) && pend_q.v);
`endif
  end

`ifndef ALU_ISSUE_STICKY_V_EN
  logic unused_flag_clr;
  assign unused_flag_clr = flag_clr;
`endif

  // NOTE: sequential state uses <= only, so every flop samples pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      instr_q    <= '0;
      ready_q    <= 1'b1;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      pend_q     <= '0;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      ready_q    <= ready_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      pend_q     <= pend_d;
      flags_q    <= flags_d;
    end
  end

  assign iss.instr_ready = ready_q;
  assign wb_valid        = wb_valid_q;
  assign wb_rd           = wb_rd_q;
  assign wb_data         = wb_data_q;
  assign flag_c          = flags_q.c;
  assign flag_z          = flags_q.z;
  assign flag_v          = flags_q.v;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: table vectors, hand-written multi-cycle sequences and random
// instructions checked against a register-array model of the controller plus ALU.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int DATA_W = 4;
  localparam int NREG   = 4;
  localparam int AW     = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.DATA_W(DATA_W), .AW(AW)) iss ();

  logic [DATA_W-1:0] alu_a, alu_b, alu_result, wb_data, dbg_data;
  logic [2:0]        alu_op;
  logic              alu_carry, alu_zero, alu_overflow;
  logic              wb_valid, flag_c, flag_z, flag_v, flag_clr;
  logic [AW-1:0]     wb_rd, dbg_addr;

  alu_issue_ctrl #(.DATA_W(DATA_W), .NREG(NREG)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .iss          (iss),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .flag_c       (flag_c),
    .flag_z       (flag_z),
    .flag_v       (flag_v),
    .flag_clr     (flag_clr),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  typedef struct packed {
    logic [DATA_W-1:0] r;
    logic              c;
    logic              z;
    logic              v;
  } alu_out_t;

  // Behavioural ALU: used both as the DUT's downstream ALU and by the reference model.
  function automatic alu_out_t alu_fn(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                      input logic [2:0] op);
    alu_out_t   o;
    logic [DATA_W:0] w;
    o = '0;
    w = '0;
    case (op)
      OP_ADD: begin
        w   = {1'b0, a} + {1'b0, b};
        o.r = w[DATA_W-1:0];
        o.c = w[DATA_W];
        o.v = (a[DATA_W-1] == b[DATA_W-1]) && (o.r[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        w   = {1'b0, a} - {1'b0, b};
        o.r = w[DATA_W-1:0];
        o.c = w[DATA_W];
        o.v = (a[DATA_W-1] != b[DATA_W-1]) && (o.r[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND: o.r = a & b;
      OP_OR:  o.r = a | b;
      OP_XOR: o.r = a ^ b;
      OP_NOT: o.r = ~a;
      OP_SHL: begin o.r = {a[DATA_W-2:0], 1'b0}; o.c = a[DATA_W-1]; end
      default: begin o.r = {1'b0, a[DATA_W-1:1]}; o.c = a[0]; end
    endcase
    o.z = (o.r == '0);
    return o;
  endfunction

  alu_out_t alu_o;
  always_comb alu_o = alu_fn(alu_a, alu_b, alu_op);
  assign alu_result   = alu_o.r;
  assign alu_carry    = alu_o.c;
  assign alu_zero     = alu_o.z;
  assign alu_overflow = alu_o.v;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference model: architectural registers and status flags only.
  logic [DATA_W-1:0] m_reg [NREG];
  logic              m_c, m_z, m_v;

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_reg[i] = '0;
    m_c = 1'b0;
    m_z = 1'b0;
    m_v = 1'b0;
  endtask

  task automatic model_step(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                            input logic [AW-1:0] rs2, input logic imm_en, input logic [DATA_W-1:0] imm,
                            output alu_out_t e);
    e = alu_fn(m_reg[rs1], imm_en ? imm : m_reg[rs2], op);
    m_reg[rd] = e.r;
    m_c = e.c;
    m_z = e.z;
`ifdef ALU_ISSUE_STICKY_V_EN
    m_v = m_v | e.v;
`else
    m_v = e.v;
`endif
  endtask

  // One instruction through accept / EXEC / WB with handshake timing checks.
  task automatic run_instr(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                           input logic [AW-1:0] rs2, input logic imm_en, input logic [DATA_W-1:0] imm,
                           output logic [AW-1:0] o_rd, output logic [DATA_W-1:0] o_data,
                           output logic [2:0] o_fl, output logic [DATA_W-1:0] o_dbg);
    @(negedge clk);
    check("ready_idle", 32'(iss.instr_ready), 1);
    iss.instr_valid  = 1'b1;
    iss.instr_op     = op;
    iss.instr_rd     = rd;
    iss.instr_rs1    = rs1;
    iss.instr_rs2    = rs2;
    iss.instr_imm_en = imm_en;
    iss.instr_imm    = imm;
    @(posedge clk); #1;
    // Scramble the fields: the controller must work from its held copy.
    iss.instr_valid  = 1'b0;
    iss.instr_op     = 3'($urandom);
    iss.instr_rd     = AW'($urandom);
    iss.instr_rs1    = AW'($urandom);
    iss.instr_rs2    = AW'($urandom);
    iss.instr_imm_en = 1'($urandom);
    iss.instr_imm    = DATA_W'($urandom);
    check("ready_exec", 32'(iss.instr_ready), 0);
    check("wbv_exec", 32'(wb_valid), 0);
    @(posedge clk); #1;
    check("wbv_wb", 32'(wb_valid), 1);
    o_rd   = wb_rd;
    o_data = wb_data;
    @(posedge clk); #1;
    check("wbv_after", 32'(wb_valid), 0);
    check("ready_after", 32'(iss.instr_ready), 1);
    o_fl     = {flag_c, flag_z, flag_v};
    dbg_addr = rd;
    #1;
    o_dbg = dbg_data;
  endtask

  typedef struct packed {
    logic [2:0]        op;
    logic [AW-1:0]     rd;
    logic [AW-1:0]     rs1;
    logic [AW-1:0]     rs2;
    logic              imm_en;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] exp_data;
    logic [2:0]        exp_fl;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #200000;
    $display("FAIL watchdog: time=%0t, limit=200000", $time);
    $fatal(1);
  end

  initial begin
    logic [AW-1:0]     o_rd;
    logic [DATA_W-1:0] o_data, o_dbg;
    logic [2:0]        o_fl;
    alu_out_t          e;
    int                low_cnt, wb_cnt;

    //            op      rd    rs1   rs2   imm   immv   data   {c,z,v}
    vecs[0]  = '{OP_OR,  2'd1, 2'd0, 2'd0, 1'b1, 4'd7, 4'd7,  3'b000};
    vecs[1]  = '{OP_OR,  2'd2, 2'd0, 2'd0, 1'b1, 4'd9, 4'd9,  3'b000};
    vecs[2]  = '{OP_ADD, 2'd3, 2'd1, 2'd2, 1'b0, 4'd0, 4'd0,  3'b110};
    vecs[3]  = '{OP_SUB, 2'd3, 2'd1, 2'd0, 1'b1, 4'd3, 4'd4,  3'b000};
    vecs[4]  = '{OP_SHL, 2'd3, 2'd2, 2'd0, 1'b0, 4'd0, 4'd2,  3'b100};
    vecs[5]  = '{OP_SHR, 2'd3, 2'd2, 2'd1, 1'b0, 4'd0, 4'd4,  3'b100};
    vecs[6]  = '{OP_NOT, 2'd3, 2'd1, 2'd0, 1'b1, 4'd5, 4'd8,  3'b000};
    vecs[7]  = '{OP_AND, 2'd3, 2'd1, 2'd2, 1'b0, 4'd0, 4'd1,  3'b000};
    vecs[8]  = '{OP_XOR, 2'd3, 2'd1, 2'd0, 1'b1, 4'd7, 4'd0,  3'b010};
    vecs[9]  = '{OP_OR,  2'd1, 2'd0, 2'd0, 1'b1, 4'd8, 4'd8,  3'b000};
    vecs[10] = '{OP_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 4'd8, 4'd0,  3'b111};

    rst_n            = 1'b0;
    iss.instr_valid  = 1'b0;
    iss.instr_op     = 3'd0;
    iss.instr_rd     = '0;
    iss.instr_rs1    = '0;
    iss.instr_rs2    = '0;
    iss.instr_imm_en = 1'b0;
    iss.instr_imm    = '0;
    flag_clr         = 1'b0;
    dbg_addr         = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", 32'(iss.instr_ready), 1);
    check("rst_wbv", 32'(wb_valid), 0);
    check("rst_flags", 32'({flag_c, flag_z, flag_v}), 0);
    for (int i = 0; i < NREG; i++) begin
      dbg_addr = AW'(i);
      #1;
      check($sformatf("rst_dbg_r%0d", i), 32'(dbg_data), 0);
    end

    // Table vectors
    for (int i = 0; i < 11; i++) begin
      run_instr(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm_en, vecs[i].imm,
                o_rd, o_data, o_fl, o_dbg);
      model_step(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm_en, vecs[i].imm, e);
      check($sformatf("tbl%0d_rd", i), 32'(o_rd), 32'(vecs[i].rd));
      check($sformatf("tbl%0d_data", i), 32'(o_data), 32'(vecs[i].exp_data));
      check($sformatf("tbl%0d_flags", i), 32'(o_fl), 32'(vecs[i].exp_fl));
      check($sformatf("tbl%0d_dbg", i), 32'(o_dbg), 32'(vecs[i].exp_data));
    end

    // V behaviour after a non-overflowing op, then flag_clr
    run_instr(OP_AND, 2'd3, 2'd1, 2'd1, 1'b0, 4'd0, o_rd, o_data, o_fl, o_dbg);
    model_step(OP_AND, 2'd3, 2'd1, 2'd1, 1'b0, 4'd0, e);
    check("and_data", 32'(o_data), 8);
`ifdef ALU_ISSUE_STICKY_V_EN
    check("and_sticky_v", 32'(o_fl[0]), 1);
`else
    check("and_last_v", 32'(o_fl[0]), 0);
`endif
    @(negedge clk);
    flag_clr = 1'b1;
    @(posedge clk); #1;
    flag_clr = 1'b0;
    m_v = 1'b0;
    check("clr_v", 32'(flag_v), 0);
    check("clr_keeps_cz", 32'({flag_c, flag_z}), 32'({m_c, m_z}));

    // flag_clr held through an overflowing op: the writeback set wins
    flag_clr = 1'b1;
    run_instr(OP_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 4'd8, o_rd, o_data, o_fl, o_dbg);
    flag_clr = 1'b0;
    model_step(OP_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 4'd8, e);
    check("setwins_flags", 32'(o_fl), 32'(3'b111));

    // Back-to-back: valid held high with two queued instructions
    @(negedge clk);
    check("b2b_ready0", 32'(iss.instr_ready), 1);
    iss.instr_valid  = 1'b1;
    iss.instr_op     = OP_OR;
    iss.instr_rd     = 2'd1;
    iss.instr_rs1    = 2'd0;
    iss.instr_rs2    = 2'd0;
    iss.instr_imm_en = 1'b1;
    iss.instr_imm    = 4'd5;
    @(posedge clk); #1;
    model_step(OP_OR, 2'd1, 2'd0, 2'd0, 1'b1, 4'd5, e);
    iss.instr_op     = OP_ADD;
    iss.instr_rd     = 2'd2;
    iss.instr_rs1    = 2'd1;
    iss.instr_imm    = 4'd1;
    low_cnt = 0;
    wb_cnt  = 0;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) begin
        check("b2b_accept_e3", 32'(iss.instr_ready), 0);
        iss.instr_valid = 1'b0;
      end
      if (k < 3 && !iss.instr_ready) low_cnt++;
      if (wb_valid) wb_cnt++;
      @(posedge clk); #1;
    end
    model_step(OP_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 4'd1, e);
    check("b2b_ready_low", 32'(low_cnt), 2);
    check("b2b_wb_pulses", 32'(wb_cnt), 2);
    check("b2b_ready_end", 32'(iss.instr_ready), 1);
    dbg_addr = 2'd1; #1;
    check("b2b_r1", 32'(dbg_data), 32'(m_reg[1]));
    dbg_addr = 2'd2; #1;
    check("b2b_r2", 32'(dbg_data), 32'(m_reg[2]));

    // Random instructions against the model
    for (int n = 0; n < 40; n++) begin
      logic [2:0]        r_op;
      logic [AW-1:0]     r_rd, r_rs1, r_rs2;
      logic              r_ie;
      logic [DATA_W-1:0] r_imm;
      r_op  = 3'($urandom_range(0, 7));
      r_rd  = AW'($urandom_range(0, NREG - 1));
      r_rs1 = AW'($urandom_range(0, NREG - 1));
      r_rs2 = AW'($urandom_range(0, NREG - 1));
      r_ie  = 1'($urandom_range(0, 1));
      r_imm = DATA_W'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_instr(r_op, r_rd, r_rs1, r_rs2, r_ie, r_imm, o_rd, o_data, o_fl, o_dbg);
      model_step(r_op, r_rd, r_rs1, r_rs2, r_ie, r_imm, e);
      check($sformatf("rnd%0d_rd", n), 32'(o_rd), 32'(r_rd));
      check($sformatf("rnd%0d_data", n), 32'(o_data), 32'(e.r));
      check($sformatf("rnd%0d_flags", n), 32'(o_fl), 32'({m_c, m_z, m_v}));
      check($sformatf("rnd%0d_dbg", n), 32'(o_dbg), 32'(m_reg[r_rd]));
    end

    // Make r1 non-zero, then abort SUB r1,r0,#3 with reset during EXEC
    run_instr(OP_OR, 2'd1, 2'd1, 2'd0, 1'b1, 4'd15, o_rd, o_data, o_fl, o_dbg);
    model_step(OP_OR, 2'd1, 2'd1, 2'd0, 1'b1, 4'd15, e);
    check("pre_rst_r1", 32'(o_dbg), 15);
    @(negedge clk);
    iss.instr_valid  = 1'b1;
    iss.instr_op     = OP_SUB;
    iss.instr_rd     = 2'd1;
    iss.instr_rs1    = 2'd0;
    iss.instr_imm_en = 1'b1;
    iss.instr_imm    = 4'd3;
    @(posedge clk); #1;
    iss.instr_valid = 1'b0;
    check("abort_in_exec", 32'(iss.instr_ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_ready_now", 32'(iss.instr_ready), 1);
    check("abort_wbv_now", 32'(wb_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    wb_cnt = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (wb_valid) wb_cnt++;
    end
    check("abort_no_wb", 32'(wb_cnt), 0);
    check("abort_flags", 32'({flag_c, flag_z, flag_v}), 0);
    dbg_addr = 2'd1; #1;
    check("abort_r1", 32'(dbg_data), 0);

    // Recovery after the abort
    run_instr(OP_OR, 2'd2, 2'd0, 2'd0, 1'b1, 4'd5, o_rd, o_data, o_fl, o_dbg);
    model_step(OP_OR, 2'd2, 2'd0, 2'd0, 1'b1, 4'd5, e);
    check("recover_data", 32'(o_data), 32'(e.r));
    check("recover_dbg", 32'(o_dbg), 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
